wb_stage: RTL



---
 rtl/wb_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - br32 writeback/commit stage: rf/cr commit, system registers, trap/eret redirect and squash
// Optional CYCLE/INSTRET counters are built only when WB_PERFCNT_EN is defined.
module wb_stage #(
    parameter logic [31:0] RESET_EVEC  = 32'h0000_0100,
    parameter int          FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mo_pc,
    input  logic [31:0] mo_nextpc,
    input  logic [31:0] mo_res,
    input  logic [31:0] mo_op3,
    input  logic [31:0] mo_alu_res,
    input  logic [4:0]  mo_rd,
    input  logic        mo_w_rd,
    input  logic        mo_w_cr,
    input  logic        mo_mtsr,
    input  logic        mo_scall,
    input  logic        mo_eret,
    input  logic        mo_udf,
    input  logic        mo_bubble,
    input  logic [1:0]  mo_cmp_res,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        cr_we,
    output logic [1:0]  cr_wdata,
    input  logic [2:0]  sr_raddr,
    output logic [31:0] sr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        retire
);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t      state;
    logic [2:0]  sq_cnt;
    logic        mode;
    logic        pmode;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] evec;
    logic [31:0] scratch;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    logic valid;
    logic trap;
    logic do_eret;
    logic commit;

    // ALU result travels with the bundle but the committed value is mo_res.
    logic unused_alu;
    assign unused_alu = ^mo_alu_res;

    always_comb begin
        valid   = !rst && !mo_bubble && (state == RUN);
        trap    = valid && (mo_udf || mo_scall);
        do_eret = valid && !trap && mo_eret;
        commit  = valid && !mo_udf && !mo_scall && !mo_eret;

        rf_we       = commit && mo_w_rd && (mo_rd != 5'd0);
        rf_waddr    = commit ? mo_rd : 5'd0;
        rf_wdata    = commit ? mo_res : 32'd0;
        cr_we       = commit && mo_w_cr;
        cr_wdata    = commit ? mo_cmp_res : 2'd0;
        redirect    = trap || do_eret;
        redirect_pc = trap ? evec : (do_eret ? epc : 32'd0);
        retire      = commit || do_eret;
    end

    always_comb begin
        sr_rdata = 32'd0;
        case (sr_raddr)
            3'd0:    sr_rdata = {30'd0, pmode, mode};
            3'd1:    sr_rdata = epc;
            3'd2:    sr_rdata = cause;
            3'd3:    sr_rdata = evec;
            3'd4:    sr_rdata = cycle_cnt;
            3'd5:    sr_rdata = instret_cnt;
            default: sr_rdata = scratch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            sq_cnt  <= 3'd0;
            mode    <= 1'b1;
            pmode   <= 1'b0;
            epc     <= 32'd0;
            cause   <= 32'd0;
            evec    <= RESET_EVEC;
            scratch <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        state  <= SQUASH;
                        sq_cnt <= 3'(FLUSH_DEPTH - 1);
                    end
                end
                SQUASH: begin
                    if (sq_cnt == 3'd0) begin
                        state <= RUN;
                    end else begin
                        sq_cnt <= sq_cnt - 3'd1;
                    end
                end
                default: state <= RUN;
            endcase

            if (trap) begin
                epc   <= mo_udf ? mo_pc : mo_nextpc;
                cause <= mo_udf ? 32'd1 : 32'd2;
                pmode <= mode;
                mode  <= 1'b1;
            end else if (do_eret) begin
                mode <= pmode;
            end else if (commit && mo_mtsr) begin
                // Indices 4/5 are read-only counters; 6 and 7 both name SCRATCH.
                case (mo_rd[2:0])
                    3'd0:    {pmode, mode} <= mo_op3[1:0];
                    3'd1:    epc <= mo_op3;
                    3'd2:    cause <= mo_op3;
                    3'd3:    evec <= mo_op3;
                    3'd6,
                    3'd7:    scratch <= mo_op3;
                    default: ;
                endcase
            end
        end
    end

`ifdef WB_PERFCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (retire) begin
                instret_cnt <= instret_cnt + 32'd1;
            end
        end
    end
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule
